// File: rtl/i2c_primary_ctrl.sv
// I2C primary: START, 7-bit address + RnW, one 16-bit word written or read (HI then LO), STOP.
// Every bit slot is four phases of Q clocks; SCL is low in phases 0-1 and high in phases 2-3.
module i2c_primary_ctrl #(
    parameter int Q = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stb,
    input  logic        rnw,
    input  logic [6:0]  i2c_addr,
    input  logic [15:0] wr_data,
    input  logic        sda_in,
    output logic        scl,
    output logic        sda_out,
    output logic        sda_oe,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        nack
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_A_ACK,
        S_WR_BYTE,
        S_W_ACK,
        S_RD_BYTE,
        S_R_ACK,
        S_STOP
    } state_t;

    localparam logic [7:0] Q_LAST = 8'(Q - 1);

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  qcnt_reg;
    logic [1:0]  phase_reg;
    logic [2:0]  bit_cnt_reg;
    logic        byte_sel_reg;
    logic [6:0]  addr_reg;
    logic        rnw_reg;
    logic [15:0] wdata_reg;
    logic [15:0] shift_reg;
    logic        ack_reg;
    logic        nack_reg;
    logic        done_reg;
    logic [15:0] rd_data_reg;

    logic        slot_end;
    logic        sample_pt;
    logic        accept;
    logic        in_byte;
    logic        in_ack;
    logic [7:0]  tx_byte;
    logic [7:0]  tx_byte_rev;
    logic        tx_bit;

    assign slot_end  = (phase_reg == 2'd3) && (qcnt_reg == Q_LAST);
    assign sample_pt = (phase_reg == 2'd2) && (qcnt_reg == 8'd0);
    assign accept    = (state_reg == S_IDLE) && start_stb;
    assign in_byte   = (state_reg == S_ADDR) || (state_reg == S_WR_BYTE) || (state_reg == S_RD_BYTE);
    assign in_ack    = (state_reg == S_A_ACK) || (state_reg == S_W_ACK);

    always_comb begin
        tx_byte = {addr_reg, rnw_reg};
        if (state_reg == S_WR_BYTE) begin
            tx_byte = byte_sel_reg ? wdata_reg[7:0] : wdata_reg[15:8];
        end
    end

    // Bit-reversed copy so the slot counter indexes MSB-first directly.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rev
            assign tx_byte_rev[gi] = tx_byte[7-gi];
        end
    endgenerate
    assign tx_bit = tx_byte_rev[bit_cnt_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start_stb) state_next = S_START;
            S_START:   if (slot_end) state_next = S_ADDR;
            S_ADDR:    if (slot_end && (bit_cnt_reg == 3'd7)) state_next = S_A_ACK;
            S_A_ACK: begin
                if (slot_end) begin
                    if (ack_reg)      state_next = S_STOP;
                    else if (rnw_reg) state_next = S_RD_BYTE;
                    else              state_next = S_WR_BYTE;
                end
            end
            S_WR_BYTE: if (slot_end && (bit_cnt_reg == 3'd7)) state_next = S_W_ACK;
            S_W_ACK: begin
                if (slot_end) state_next = (ack_reg || byte_sel_reg) ? S_STOP : S_WR_BYTE;
            end
            S_RD_BYTE: if (slot_end && (bit_cnt_reg == 3'd7)) state_next = S_R_ACK;
            S_R_ACK: begin
                if (slot_end) state_next = byte_sel_reg ? S_STOP : S_RD_BYTE;
            end
            S_STOP:    if (slot_end) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Counters idle at zero so an accepted strobe starts START at phase 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            qcnt_reg     <= 8'd0;
            phase_reg    <= 2'd0;
            bit_cnt_reg  <= 3'd0;
            byte_sel_reg <= 1'b0;
        end else if (state_reg == S_IDLE) begin
            qcnt_reg     <= 8'd0;
            phase_reg    <= 2'd0;
            bit_cnt_reg  <= 3'd0;
            byte_sel_reg <= 1'b0;
        end else begin
            if (qcnt_reg == Q_LAST) begin
                qcnt_reg  <= 8'd0;
                phase_reg <= phase_reg + 2'd1;
            end else begin
                qcnt_reg <= qcnt_reg + 8'd1;
            end
            if (slot_end) begin
                if (in_byte) begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
                if ((state_reg == S_W_ACK) || (state_reg == S_R_ACK)) begin
                    byte_sel_reg <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg    <= 7'd0;
            rnw_reg     <= 1'b0;
            wdata_reg   <= 16'd0;
            shift_reg   <= 16'd0;
            ack_reg     <= 1'b1;
            nack_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rd_data_reg <= 16'd0;
        end else begin
            done_reg <= (state_reg == S_STOP) && slot_end;
            if (accept) begin
                addr_reg  <= i2c_addr;
                rnw_reg   <= rnw;
                wdata_reg <= wr_data;
                nack_reg  <= 1'b0;
                shift_reg <= 16'd0;
            end
            if (sample_pt && in_ack) begin
                ack_reg <= sda_in;
            end
            if (sample_pt && (state_reg == S_RD_BYTE)) begin
                shift_reg <= {shift_reg[14:0], sda_in};
            end
            if (slot_end && in_ack && ack_reg) begin
                nack_reg <= 1'b1;
            end
            // Only a read that got through its address ACK publishes new data.
            if (slot_end && (state_reg == S_STOP) && rnw_reg && !nack_reg) begin
                rd_data_reg <= shift_reg;
            end
        end
    end

    always_comb begin
        scl     = 1'b1;
        sda_out = 1'b1;
        sda_oe  = 1'b1;
        busy    = (state_reg != S_IDLE);
        case (state_reg)
            S_IDLE: begin
                scl = 1'b1;
            end
            S_START: begin
                sda_out = (phase_reg < 2'd2);
            end
            S_ADDR, S_WR_BYTE: begin
                scl     = phase_reg[1];
                sda_out = tx_bit;
            end
            S_A_ACK, S_W_ACK, S_RD_BYTE: begin
                scl    = phase_reg[1];
                sda_oe = 1'b0;
            end
            S_R_ACK: begin
                scl     = phase_reg[1];
                sda_out = byte_sel_reg;
            end
            S_STOP: begin
                scl     = phase_reg[1];
                sda_out = (phase_reg == 2'd3);
            end
            default: begin
                scl = 1'b1;
            end
        endcase
    end

    assign done    = done_reg;
    assign nack    = nack_reg;
    assign rd_data = rd_data_reg;

endmodule
